// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART boot loader: state encoding and frame constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    localparam int LEN_BYTES              = 2;
    localparam int CSUM_WIDTH             = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four little-endian payload bytes into a 32-bit word and flags completion.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] data_q, data_d;

    // The fourth byte is never stored; it is merged straight into the output word.
    assign word_o      = {byte_i, data_q};
    assign word_done_o = byte_valid_i && (idx_q == 2'd3);

    // Next byte position and partial-word contents.
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        if (clear_i) begin
            idx_d  = 2'd0;
            data_d = 24'd0;
        end else if (byte_valid_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    data_d[7:0]   = byte_i;
                2'd1:    data_d[15:8]  = byte_i;
                2'd2:    data_d[23:16] = byte_i;
                default: data_d        = data_q;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            data_q <= 24'd0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// UART boot loader and instruction-memory fetch-address mux; holds the CPU in reset
// while a length-prefixed, XOR-checksummed program image is written from word 0.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic [31:0]           pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_we,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS  = 17'(2 ** ADDR_WIDTH);

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             wc_q, wc_d;
    logic [CSUM_WIDTH-1:0]   csum_q, csum_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;

    logic                    receiving_s, xfer_s, start_s;
    logic [31:0]             word_s;
    logic                    word_done_s;
    logic [15:0]             len_rx_s;
    logic                    unused_pc_s;

    assign receiving_s = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                         (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign xfer_s      = rx_valid && receiving_s;
    assign len_rx_s    = {rx_data, len_q[7:0]};
    assign unused_pc_s = ^{pc[31:ADDR_WIDTH+2], pc[1:0]};

    assign rx_ready   = receiving_s;
    assign busy       = receiving_s;
    // Outside IDLE the address holds the last write target, so a wrapped count is never presented.
    assign imem_addr  = (state_q == ST_IDLE) ? pc[ADDR_WIDTH+1:2] : waddr_q;
    assign imem_we    = we_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = wc_q;

    word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_s),
        .byte_valid_i (xfer_s && (state_q == ST_DATA)),
        .byte_i       (rx_data),
        .word_o       (word_s),
        .word_done_o  (word_done_s)
    );

    // Session FSM, checksum, write issue and inter-byte timeout.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wc_d    = wc_q;
        csum_d  = csum_q;
        timer_d = timer_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        start_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (load_req) begin
                    start_s = 1'b1;
                    state_d = ST_LEN_LO;
                    len_d   = 16'd0;
                    wc_d    = 16'd0;
                    csum_d  = '0;
                    timer_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    len_d = len_rx_s;
                    if ({1'b0, len_rx_s} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (len_rx_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    csum_d = csum_q ^ rx_data;
                    if (word_done_s) begin
                        we_d    = 1'b1;
                        waddr_d = wc_q[ADDR_WIDTH-1:0];
                        wdata_d = word_s;
                        wc_d    = wc_q + 16'd1;
                        state_d = ((wc_q + 16'd1) == len_q) ? ST_CSUM : ST_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    if (rx_data == csum_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (receiving_s) begin
            if (xfer_s) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                timer_d = '0;
                state_d = ST_ERROR;
                error_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = timer_d;
        end

        cpu_rst_n_d = (state_d == ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 16'd0;
            wc_q        <= 16'd0;
            csum_q      <= '0;
            timer_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wc_q        <= wc_d;
            csum_q      <= csum_d;
            timer_q     <= timer_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=14, TIMEOUT_CYCLES=100).
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [31:0] pc = 32'h0;
    logic [13:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.ADDR_WIDTH(14), .TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .pc         (pc),
        .imem_addr  (imem_addr),
        .imem_we    (imem_we),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Write monitor: one entry per cycle with imem_we high.
    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Ends on the negedge of the cycle right after the last byte transferred.
    task automatic send_frame(input bq_t f);
        for (int i = 0; i < f.size(); i++) send_byte(f[i]);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        rx_valid = 1'b0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if (imem_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", imem_we); else pass_cnt++;
        total_cnt++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", imem_wdata); else pass_cnt++;
        total_cnt++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd0) $display("FAIL reset_word_count got=%0d exp=0", word_count); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL first_cycle_cpu_rst_n got=%b exp=0", cpu_rst_n); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL release_cpu_rst_n got=%b exp=1", cpu_rst_n); else pass_cnt++;
    endtask

    task automatic test_idle_passthrough();
        pc = 32'h0000_0010; #1;
        total_cnt++; if (imem_addr !== 14'd4) $display("FAIL pc_0x10 got=%0d exp=4", imem_addr); else pass_cnt++;
        pc = 32'h0000_0013; #1;
        total_cnt++; if (imem_addr !== 14'd4) $display("FAIL pc_0x13 got=%0d exp=4", imem_addr); else pass_cnt++;
        pc = 32'h0001_0008; #1;
        total_cnt++; if (imem_addr !== 14'd2) $display("FAIL pc_high_bits got=%0d exp=2", imem_addr); else pass_cnt++;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h55; #1;
        total_cnt++; if (rx_ready !== 1'b0) $display("FAIL idle_rx_ready got=%b exp=0", rx_ready); else pass_cnt++;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_two_word();
        bq_t f;
        clear_log();
        pc = 32'h0000_0020;
        pulse_load();
        total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL entry_cpu_rst_n got=%b exp=0", cpu_rst_n); else pass_cnt++;
        total_cnt++; if ({rx_ready, busy} !== 2'b11) $display("FAIL entry_ready_busy got=%b exp=11", {rx_ready, busy}); else pass_cnt++;
        // Checksum is the XOR of the payload bytes: 13 ^ 93 ^ 10 = 90.
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(f);
        total_cnt++; if (wr_addr.size() !== 2) $display("FAIL two_word_nwrites got=%0d exp=2", wr_addr.size()); else pass_cnt++;
        total_cnt++; if ((wr_addr.size() > 0 ? {wr_addr[0], wr_data[0]} : 46'bx) !== {14'd0, 32'h0000_0013})
            $display("FAIL two_word_wr0 got=%h exp=%h", (wr_addr.size() > 0 ? {wr_addr[0], wr_data[0]} : 46'bx), {14'd0, 32'h0000_0013}); else pass_cnt++;
        total_cnt++; if ((wr_addr.size() > 1 ? {wr_addr[1], wr_data[1]} : 46'bx) !== {14'd1, 32'h0010_0093})
            $display("FAIL two_word_wr1 got=%h exp=%h", (wr_addr.size() > 1 ? {wr_addr[1], wr_data[1]} : 46'bx), {14'd1, 32'h0010_0093}); else pass_cnt++;
        total_cnt++; if (word_count !== 16'd2) $display("FAIL two_word_count got=%0d exp=2", word_count); else pass_cnt++;
        total_cnt++; if ({done, error, busy, cpu_rst_n} !== 4'b1001) $display("FAIL two_word_exit got=%b exp=1001", {done, error, busy, cpu_rst_n}); else pass_cnt++;
        total_cnt++; if (imem_addr !== 14'd8) $display("FAIL two_word_fetch_mux got=%0d exp=8", imem_addr); else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        bq_t f;
        clear_log();
        pulse_load();
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h9A};
        send_frame(f);
        total_cnt++; if ({done, error, busy, cpu_rst_n} !== 4'b0100) $display("FAIL bad_csum_flags got=%b exp=0100", {done, error, busy, cpu_rst_n}); else pass_cnt++;
        rx_valid = 1'b1; rx_data = 8'h11;
        repeat (5) @(negedge clk);
        total_cnt++; if ({rx_ready, cpu_rst_n, error} !== 3'b001) $display("FAIL error_hold got=%b exp=001", {rx_ready, cpu_rst_n, error}); else pass_cnt++;
        rx_valid = 1'b0;
        clear_log();
        pulse_load();
        total_cnt++; if ({error, busy} !== 2'b01) $display("FAIL recover_entry got=%b exp=01", {error, busy}); else pass_cnt++;
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(f);
        total_cnt++; if ({done, error, cpu_rst_n} !== 3'b101) $display("FAIL recover_exit got=%b exp=101", {done, error, cpu_rst_n}); else pass_cnt++;
        total_cnt++; if (wr_addr.size() !== 2) $display("FAIL recover_nwrites got=%0d exp=2", wr_addr.size()); else pass_cnt++;
    endtask

    task automatic test_zero_and_oversize();
        bq_t f;
        clear_log();
        pulse_load();
        f = '{8'h00, 8'h00, 8'h00};
        send_frame(f);
        total_cnt++; if ({done, error, cpu_rst_n} !== 3'b101) $display("FAIL zero_len_exit got=%b exp=101", {done, error, cpu_rst_n}); else pass_cnt++;
        total_cnt++; if (wr_addr.size() !== 0) $display("FAIL zero_len_nwrites got=%0d exp=0", wr_addr.size()); else pass_cnt++;
        pulse_load();
        f = '{8'h01, 8'h40};
        send_frame(f);
        total_cnt++; if ({error, busy, rx_ready, cpu_rst_n} !== 4'b1000) $display("FAIL oversize_flags got=%b exp=1000", {error, busy, rx_ready, cpu_rst_n}); else pass_cnt++;
        total_cnt++; if (wr_addr.size() !== 0) $display("FAIL oversize_nwrites got=%0d exp=0", wr_addr.size()); else pass_cnt++;
    endtask

    task automatic test_timeout();
        bq_t f;
        int early_err;
        clear_log();
        pulse_load();
        f = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_frame(f);
        early_err = 0;
        // Already one cycle past the last accepted byte; look after idle edges 1..99.
        if (error !== 1'b0) early_err++;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (error !== 1'b0) early_err++;
        end
        total_cnt++; if (early_err !== 0) $display("FAIL timeout_early got=%0d exp=0", early_err); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({error, busy, cpu_rst_n} !== 3'b100) $display("FAIL timeout_fire got=%b exp=100", {error, busy, cpu_rst_n}); else pass_cnt++;
        total_cnt++; if (wr_addr.size() !== 0 || word_count !== 16'd0) $display("FAIL timeout_partial got=%0d/%0d exp=0/0", wr_addr.size(), word_count); else pass_cnt++;
    endtask

    task automatic test_ignore_load_req();
        bq_t f;
        clear_log();
        pulse_load();
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(f);
        total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 14'd0, 32'h13}) $display("FAIL write_latency got=%h exp=%h", {imem_we, imem_addr, imem_wdata}, {1'b1, 14'd0, 32'h13}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (imem_we !== 1'b0) $display("FAIL write_one_cycle got=%b exp=0", imem_we); else pass_cnt++;
        pulse_load();
        total_cnt++; if ({busy, word_count} !== {1'b1, 16'd1}) $display("FAIL ignore_load got=%h exp=%h", {busy, word_count}, {1'b1, 16'd1}); else pass_cnt++;
        f = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(f);
        total_cnt++; if ({done, error, word_count} !== {2'b10, 16'd2}) $display("FAIL ignore_exit got=%h exp=%h", {done, error, word_count}, {2'b10, 16'd2}); else pass_cnt++;
        total_cnt++; if ((wr_addr.size() > 1 ? {wr_addr[1], wr_data[1]} : 46'bx) !== {14'd1, 32'h0010_0093})
            $display("FAIL ignore_wr1 got=%h exp=%h", (wr_addr.size() > 1 ? {wr_addr[1], wr_data[1]} : 46'bx), {14'd1, 32'h0010_0093}); else pass_cnt++;
    endtask

    task automatic test_abort();
        bq_t f;
        pc = 32'h0000_0040;
        pulse_load();
        f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_frame(f);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({busy, done, error, imem_we, cpu_rst_n, rx_ready} !== 6'b000000) $display("FAIL abort_flags got=%b exp=000000", {busy, done, error, imem_we, cpu_rst_n, rx_ready}); else pass_cnt++;
        total_cnt++; if ({word_count, imem_wdata} !== 48'h0) $display("FAIL abort_data got=%h exp=0", {word_count, imem_wdata}); else pass_cnt++;
        total_cnt++; if (imem_addr !== 14'd16) $display("FAIL abort_fetch_mux got=%0d exp=16", imem_addr); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        rx_valid = 1'b1; rx_data = 8'h00;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        total_cnt++; if ({wr_addr.size() == 0, busy, cpu_rst_n} !== 3'b101) $display("FAIL abort_after got=%b exp=101", {wr_addr.size() == 0, busy, cpu_rst_n}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_two_word();
        test_bad_checksum();
        test_zero_and_oversize();
        test_timeout();
        test_ignore_load_req();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
